// File: rtl/awsf1_pcim_rd_arb.sv
`default_nettype none
// ============================================================================
// Module   : awsf1_pcim_rd_arb
// Brief    : Round-robin arbiter sharing the PCIM AXI4 read master among
//            NUM_REQ DMA read engines. Optional counters: PCIM_RD_ARB_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module awsf1_pcim_rd_arb #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_OUTST = 8,
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 512,
    parameter int ID_W      = 16
) (
    input  logic                      clk_main_a0,
    input  logic                      rst_main_n,
    input  logic [NUM_REQ-1:0]        req_arvalid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_araddr,
    input  logic [NUM_REQ*8-1:0]      req_arlen,
    output logic [NUM_REQ-1:0]        req_arready,
    output logic [NUM_REQ-1:0]        req_rvalid,
    output logic [DATA_W-1:0]         req_rdata,
    output logic [1:0]                req_rresp,
    output logic                      req_rlast,
    input  logic [NUM_REQ-1:0]        req_rready,
    output logic                      pcim_arvalid,
    output logic [ADDR_W-1:0]         pcim_araddr,
    output logic [ID_W-1:0]           pcim_arid,
    output logic [7:0]                pcim_arlen,
    output logic [2:0]                pcim_arsize,
    input  logic                      pcim_arready,
    input  logic                      pcim_rvalid,
    input  logic [DATA_W-1:0]         pcim_rdata,
    input  logic [ID_W-1:0]           pcim_rid,
    input  logic [1:0]                pcim_rresp,
    input  logic                      pcim_rlast,
    output logic                      pcim_rready,
    output logic                      rid_err
`ifdef PCIM_RD_ARB_PERF_EN
    ,
    input  logic                      perf_clr,
    output logic [31:0]               perf_grant_cnt,
    output logic [31:0]               perf_stall_cnt
`endif
);

    localparam int              IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int              CW          = $clog2(MAX_OUTST + 1);
    localparam logic [IDX_W:0]  NUM_REQ_V   = (IDX_W+1)'(NUM_REQ);
    localparam logic [CW-1:0]   MAX_OUTST_V = CW'(MAX_OUTST);
    localparam logic [IDX_W-1:0] LAST_RST   = IDX_W'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   last;
    logic [CW-1:0]      outst [NUM_REQ];
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] cnt_inc;
    logic [NUM_REQ-1:0] cnt_dec;
    logic               grant_found;
    logic               grant_fire;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W:0]     cand;
    logic [ADDR_W-1:0]  sel_addr;
    logic [7:0]         sel_len;
    logic [IDX_W-1:0]   r_idx;
    logic               r_idx_ok;
    logic               cmpl;
    logic               unused_rid_hi;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign eligible[gi] = req_arvalid[gi] && (outst[gi] < MAX_OUTST_V);
            assign cnt_inc[gi]  = grant_fire && (grant_idx == IDX_W'(gi));
            assign cnt_dec[gi]  = cmpl && (r_idx == IDX_W'(gi)) && (outst[gi] != '0);
        end
    endgenerate

    // Search starts just after the last requester that completed an AR handshake.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last} + (IDX_W+1)'(k);
            if (cand >= NUM_REQ_V) cand = cand - NUM_REQ_V;
            if (!grant_found && eligible[cand[IDX_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel_addr = req_araddr[i*ADDR_W +: ADDR_W];
                sel_len  = req_arlen[i*8 +: 8];
            end
        end
    end

    // The accept pulse is combinational, so it is gated off while reset is held.
    assign grant_fire  = (state == S_IDLE) && grant_found && rst_main_n;
    assign req_arready = grant_fire ? (NUM_REQ'(1) << grant_idx) : '0;
    assign pcim_arsize = 3'b110;

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            state        <= S_IDLE;
            last         <= LAST_RST;
            pcim_arvalid <= 1'b0;
            pcim_araddr  <= '0;
            pcim_arid    <= '0;
            pcim_arlen   <= '0;
            rid_err      <= 1'b0;
        end else begin
            if (pcim_rvalid && !r_idx_ok) rid_err <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        pcim_araddr  <= sel_addr;
                        pcim_arlen   <= sel_len;
                        pcim_arid    <= {{(ID_W-IDX_W){1'b0}}, grant_idx};
                        pcim_arvalid <= 1'b1;
                        state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (pcim_arready) begin
                        pcim_arvalid <= 1'b0;
                        last         <= pcim_arid[IDX_W-1:0];
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            for (int i = 0; i < NUM_REQ; i++) outst[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (cnt_inc[i] && !cnt_dec[i])      outst[i] <= outst[i] + 1'b1;
                else if (cnt_dec[i] && !cnt_inc[i]) outst[i] <= outst[i] - 1'b1;
            end
        end
    end

    // Only the low RID bits select a requester; beats for absent indices are sunk.
    assign r_idx         = pcim_rid[IDX_W-1:0];
    assign r_idx_ok      = ({1'b0, r_idx} < NUM_REQ_V);
    assign req_rvalid    = (r_idx_ok && pcim_rvalid) ? (NUM_REQ'(1) << r_idx) : '0;
    assign pcim_rready   = r_idx_ok ? req_rready[r_idx] : 1'b1;
    assign req_rdata     = pcim_rdata;
    assign req_rresp     = pcim_rresp;
    assign req_rlast     = pcim_rlast;
    assign cmpl          = pcim_rvalid && pcim_rready && pcim_rlast && r_idx_ok;
    assign unused_rid_hi = ^pcim_rid;

`ifdef PCIM_RD_ARB_PERF_EN
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            perf_grant_cnt <= '0;
            perf_stall_cnt <= '0;
        end else if (perf_clr) begin
            perf_grant_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (pcim_arvalid && pcim_arready && (perf_grant_cnt != 32'hFFFF_FFFF))
                perf_grant_cnt <= perf_grant_cnt + 32'd1;
            if (pcim_arvalid && !pcim_arready && (perf_stall_cnt != 32'hFFFF_FFFF))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire
